// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path.
// Holds frame geometry and receiver FSM encoding.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    DATA      = ST_DATA,
    STOP      = ST_STOP,
    WAIT_IDLE = ST_WAIT_IDLE
  } rx_state_t;

  function automatic int unsigned clks_per_bit(
    input int unsigned clk_hz,
    input int unsigned baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Also used for push-button inputs.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry
// valid/ready output buffer reporting framing errors and overruns.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 27000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk_27mhz,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BCW = $clog2(CLKS_PER_BIT);
  localparam int BIW = $clog2(DATA_BITS);

  localparam logic [BCW-1:0] BC_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] BC_HALF = BCW'(HALF_BIT - 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(DATA_BITS - 1);

  logic                 w_rxs;
  rx_state_t            r_state;
  rx_state_t            w_state_nx;
  logic [BCW-1:0]       r_bc;
  logic [BCW-1:0]       w_bc_nx;
  logic [BIW-1:0]       r_bi;
  logic [BIW-1:0]       w_bi_nx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 w_shift;
  logic                 w_stop_smp;
  logic                 w_deliver;
  logic                 w_ovr;
  logic                 w_ferr;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk (clk_27mhz),
    .i_rst (rst),
    .i_d   (uart_rx),
    .o_q   (w_rxs)
  );

  always_comb begin
    w_state_nx = r_state;
    w_bc_nx    = r_bc;
    w_bi_nx    = r_bi;
    w_shift    = 1'b0;
    w_stop_smp = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_bc_nx = '0;
        if (!w_rxs) begin
          w_state_nx = START;
        end
      end
      START: begin
        if (r_bc == BC_HALF) begin
          w_bc_nx = '0;
          // a start bit that is gone by its centre was a glitch
          if (!w_rxs) begin
            w_state_nx = DATA;
            w_bi_nx    = '0;
          end else begin
            w_state_nx = IDLE;
          end
        end else begin
          w_bc_nx = r_bc + 1'b1;
        end
      end
      DATA: begin
        if (r_bc == BC_LAST) begin
          w_bc_nx = '0;
          w_shift = 1'b1;
          if (r_bi == BI_LAST) begin
            w_state_nx = STOP;
          end else begin
            w_bi_nx = r_bi + 1'b1;
          end
        end else begin
          w_bc_nx = r_bc + 1'b1;
        end
      end
      STOP: begin
        if (r_bc == BC_LAST) begin
          w_bc_nx    = '0;
          w_stop_smp = 1'b1;
          w_state_nx = w_rxs ? IDLE : WAIT_IDLE;
        end else begin
          w_bc_nx = r_bc + 1'b1;
        end
      end
      WAIT_IDLE: begin
        w_bc_nx = '0;
        if (w_rxs) begin
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_bc_nx    = '0;
        w_bi_nx    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_27mhz) begin
    if (rst) begin
      r_state <= IDLE;
      r_bc    <= '0;
      r_bi    <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nx;
      r_bc    <= w_bc_nx;
      r_bi    <= w_bi_nx;
      if (w_shift) begin
        r_shreg <= {w_rxs, r_shreg[DATA_BITS-1:1]};
      end
    end
  end

  // a full buffer still takes the new byte if it is drained this cycle
  assign w_deliver = w_stop_smp & w_rxs & (~r_valid | rx_ready);
  assign w_ovr     = w_stop_smp & w_rxs & r_valid & ~rx_ready;
  assign w_ferr    = w_stop_smp & ~w_rxs;

  always_ff @(posedge clk_27mhz) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_ovr;
      if (w_deliver) begin
        r_data  <= r_shreg;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: directed frames against a frame-level
// model of the output buffer, plus literal spot checks.
module tb_uart_rx_8n1;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  // pin start edge to stop-sample edge: 2 sync + 1 + half + 9 bits
  localparam int LAT  = 3 + HALF + 9 * CPB;

  typedef struct {
    int         at;
    logic [7:0] b;
    logic       ok;
  } ev_t;

  logic       clk_27mhz = 1'b0;
  logic       rst       = 1'b1;
  logic       uart_rx   = 1'b1;
  logic       rx_ready  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int nprint = 0;
  int cyc    = 0;

  ev_t        evq[$];
  ev_t        ev;
  logic       dlv;
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;

  int         n_hs      = 0;
  int         n_ferr    = 0;
  int         n_ovr     = 0;
  int         rise_cyc  = 0;
  int         start_cyc = 0;
  logic [7:0] hs_data   = 8'h00;
  logic       prev_v    = 1'b0;

  int b_hs;
  int b_ferr;
  int b_ovr;

  always #5 clk_27mhz = ~clk_27mhz;

  uart_rx_8n1 #(
    .CLK_HZ (1600),
    .BAUD   (100)
  ) dut (
    .clk_27mhz (clk_27mhz),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      if (nprint < 40) begin
        nprint++;
        $display("FAIL %s at cycle %0d: got %0h, expected %0h",
                 nm, cyc, act, exp);
      end
    end
  endtask

  // frame-level model: what each rising edge must leave behind
  always @(posedge clk_27mhz) begin
    cyc    = cyc + 1;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    dlv    = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      evq.delete();
    end else begin
      if (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        if (!ev.ok) m_ferr = 1'b1;
        else if (!m_valid || rx_ready) dlv = 1'b1;
        else m_ovr = 1'b1;
      end
      if (dlv) begin
        m_data  = ev.b;
        m_valid = 1'b1;
      end else if (m_valid && rx_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk_27mhz) begin
    check("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
    check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
    check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
    check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    if (rx_valid && rx_ready) begin
      n_hs++;
      hs_data = rx_data;
    end
    if (rx_valid && !prev_v) rise_cyc = cyc;
    prev_v = rx_valid;
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    ev_t e;
    @(posedge clk_27mhz);
    #1;
    start_cyc = cyc;
    e.at = start_cyc + LAT;
    e.b  = b;
    e.ok = stop;
    evq.push_back(e);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk_27mhz);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk_27mhz);
      #1;
    end
    uart_rx = stop;
    repeat (CPB) @(posedge clk_27mhz);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_27mhz);
    #1;
  endtask

  task automatic mark();
    b_hs   = n_hs;
    b_ferr = n_ferr;
    b_ovr  = n_ovr;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    rst = 1'b0;
    check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset rx_data", {24'd0, rx_data}, 32'd0);
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
    check("reset overrun", {31'd0, overrun}, 32'd0);
    idle(5);

    mark();
    send_frame(8'hA5, 1'b1);
    idle(5);
    check("a5 count", n_hs - b_hs, 32'd1);
    check("a5 data", {24'd0, hs_data}, 32'h0000_00A5);
    check("a5 latency", rise_cyc - start_cyc, 32'd155);
    check("a5 ferr", n_ferr - b_ferr, 32'd0);
    check("a5 ovr", n_ovr - b_ovr, 32'd0);

    mark();
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(40);
    check("glitch count", n_hs - b_hs, 32'd0);
    check("glitch ferr", n_ferr - b_ferr, 32'd0);

    mark();
    send_frame(8'h3C, 1'b0);
    idle(40);
    uart_rx = 1'b1;
    idle(20);
    check("break ferr", n_ferr - b_ferr, 32'd1);
    check("break count", n_hs - b_hs, 32'd0);
    send_frame(8'h81, 1'b1);
    idle(5);
    check("81 count", n_hs - b_hs, 32'd1);
    check("81 data", {24'd0, hs_data}, 32'h0000_0081);

    rx_ready = 1'b0;
    mark();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(5);
    check("ovr pulses", n_ovr - b_ovr, 32'd1);
    check("ovr valid", {31'd0, rx_valid}, 32'd1);
    check("ovr data", {24'd0, rx_data}, 32'h0000_0011);
    rx_ready = 1'b1;
    idle(2);
    check("drain valid", {31'd0, rx_valid}, 32'd0);
    check("drain data", {24'd0, rx_data}, 32'h0000_0011);
    check("drain hs", {24'd0, hs_data}, 32'h0000_0011);

    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(5);
    mark();
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk_27mhz);
        #1;
        repeat (LAT - 1) @(posedge clk_27mhz);
        #1;
        rx_ready = 1'b1;
        @(posedge clk_27mhz);
        #1;
        rx_ready = 1'b0;
      end
    join
    idle(3);
    check("swap valid", {31'd0, rx_valid}, 32'd1);
    check("swap data", {24'd0, rx_data}, 32'h0000_0055);
    check("swap ovr", n_ovr - b_ovr, 32'd0);
    rx_ready = 1'b1;
    idle(3);

    fork
      send_frame(8'hF0, 1'b1);
      begin
        @(posedge clk_27mhz);
        #1;
        repeat (CPB * 5 + 8) @(posedge clk_27mhz);
        #1;
        rst = 1'b1;
        @(posedge clk_27mhz);
        #1;
        rst = 1'b0;
        check("mid rst valid", {31'd0, rx_valid}, 32'd0);
        check("mid rst data", {24'd0, rx_data}, 32'd0);
        check("mid rst ferr", {31'd0, frame_err}, 32'd0);
        check("mid rst ovr", {31'd0, overrun}, 32'd0);
        mark();
      end
    join
    idle(20);
    check("post rst count", n_hs - b_hs, 32'd0);
    check("post rst ferr", n_ferr - b_ferr, 32'd0);
    send_frame(8'h0F, 1'b1);
    idle(5);
    check("0f count", n_hs - b_hs, 32'd1);
    check("0f data", {24'd0, hs_data}, 32'h0000_000F);
    check("queue empty", evq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
